// File: rtl/flit_inject_arbiter_if.sv
// Bus bundle for flit_inject_arbiter: per-source flit inputs, granted flit output, grant and drop counters.
// The slave modport is the arbiter's view; the master modport is the source/router side.
interface flit_inject_arbiter_if #(
  parameter int unsigned REQ_COUNT = 4,
  parameter int unsigned FW        = 22
);
  logic [REQ_COUNT-1:0]    in_valid;
  logic [REQ_COUNT*FW-1:0] in_flit;
  logic                    out_ready;
  logic                    out_valid;
  logic [FW-1:0]           out_flit;
  logic [REQ_COUNT-1:0]    grant;
  logic [REQ_COUNT*8-1:0]  drop_count;

  modport master (
    output in_valid,
    output in_flit,
    output out_ready,
    input  out_valid,
    input  out_flit,
    input  grant,
    input  drop_count
  );

  modport slave (
    input  in_valid,
    input  in_flit,
    input  out_ready,
    output out_valid,
    output out_flit,
    output grant,
    output drop_count
  );
endinterface

// File: rtl/flit_inject_arbiter.sv
// Per-source flit FIFOs sharing one router local port under packet-atomic round-robin arbitration.
// Define FLIT_ARB_DROP_COUNT_EN to build the per-source saturating drop counters.
module flit_inject_arbiter #(
  parameter int unsigned REQ_COUNT       = 4,
  parameter int unsigned NODE_COUNT      = 8,
  parameter int unsigned PACKET_ID_WIDTH = 5,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce,
  flit_inject_arbiter_if.slave bus
);
  localparam int unsigned DW = $clog2(NODE_COUNT);
  localparam int unsigned FW = 3 + 2*DW + 8 + PACKET_ID_WIDTH;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned IW = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1;

  typedef struct packed {
    logic                       valid;
    logic [DW-1:0]              dest;
    logic [7:0]                 payload;
    logic [PACKET_ID_WIDTH-1:0] packet_id;
    logic [DW-1:0]              src;
    logic [1:0]                 seq;
  } flit_t;

  typedef enum logic {IDLE, LOCKED} state_t;

  flit_t                mem    [REQ_COUNT][FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr [REQ_COUNT];
  logic [AW-1:0]        rd_ptr [REQ_COUNT];
  logic [CW-1:0]        count  [REQ_COUNT];
  logic [REQ_COUNT-1:0] full;
  logic [REQ_COUNT-1:0] wr_en;
  logic [REQ_COUNT-1:0] pop;

  state_t               state_q, state_d;
  logic [IW-1:0]        gnt_idx_q, gnt_idx_d;
  logic [IW-1:0]        last_q, last_d;
  logic [REQ_COUNT-1:0] grant_q, grant_d;

  flit_t                head;
  logic                 out_valid_c;
  logic                 xfer;
  logic                 pick_found;
  logic [IW-1:0]        pick_idx;
  logic [IW-1:0]        cand;

  // FIFO write/pop qualifiers; fullness is judged before this cycle's pop
  always_comb begin
    for (int i = 0; i < REQ_COUNT; i++) begin
      full[i]  = (count[i] == CW'(FIFO_DEPTH));
      wr_en[i] = ce && bus.in_valid[i] && !full[i];
      pop[i]   = xfer && (gnt_idx_q == IW'(i));
    end
  end

  // FIFO storage is not reset; only pointers and occupancy are
  always_ff @(posedge clk) begin
    for (int i = 0; i < REQ_COUNT; i++) begin
      if (wr_en[i]) begin
        mem[i][wr_ptr[i]] <= flit_t'(bus.in_flit[i*FW +: FW]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REQ_COUNT; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < REQ_COUNT; i++) begin
        if (wr_en[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
        if (pop[i])   rd_ptr[i] <= rd_ptr[i] + AW'(1);
        count[i] <= count[i] + CW'(wr_en[i]) - CW'(pop[i]);
      end
    end
  end

  // Arbiter state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_idx_q <= '0;
      last_q    <= IW'(REQ_COUNT - 1);
      grant_q   <= '0;
    end else begin
      state_q   <= state_d;
      gnt_idx_q <= gnt_idx_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
    end
  end

  // Next-state logic: round-robin pick in IDLE, hold the port until a seq==3 flit leaves
  always_comb begin
    state_d     = state_q;
    gnt_idx_d   = gnt_idx_q;
    last_d      = last_q;
    grant_d     = grant_q;
    out_valid_c = 1'b0;
    xfer        = 1'b0;
    pick_found  = 1'b0;
    pick_idx    = '0;
    cand        = '0;
    head        = mem[gnt_idx_q][rd_ptr[gnt_idx_q]];

    for (int k = 1; k <= REQ_COUNT; k++) begin
      cand = IW'((int'(last_q) + k) % int'(REQ_COUNT));
      if (!pick_found && (count[cand] != '0)) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end

    case (state_q)
      IDLE: begin
        if (ce && pick_found) begin
          state_d   = LOCKED;
          gnt_idx_d = pick_idx;
          grant_d   = REQ_COUNT'(1) << pick_idx;
        end
      end
      LOCKED: begin
        out_valid_c = ce && !rst && (count[gnt_idx_q] != '0);
        xfer        = out_valid_c && bus.out_ready;
        if (xfer && (head.seq == 2'd3)) begin
          state_d = IDLE;
          last_d  = gnt_idx_q;
          grant_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  assign bus.out_valid = out_valid_c;
  assign bus.out_flit  = (state_q == LOCKED) ? head : '0;
  assign bus.grant     = grant_q;

`ifdef FLIT_ARB_DROP_COUNT_EN
  logic [7:0] drop_q [REQ_COUNT];

  // Saturating count of flits that arrived at a full FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REQ_COUNT; i++) drop_q[i] <= '0;
    end else begin
      for (int i = 0; i < REQ_COUNT; i++) begin
        if (ce && bus.in_valid[i] && full[i] && (drop_q[i] != 8'hFF)) begin
          drop_q[i] <= drop_q[i] + 8'd1;
        end
      end
    end
  end

  always_comb begin
    bus.drop_count = '0;
    for (int i = 0; i < REQ_COUNT; i++) begin
      bus.drop_count[i*8 +: 8] = drop_q[i];
    end
  end
`else
  assign bus.drop_count = '0;
`endif

endmodule

// File: tb/tb_flit_inject_arbiter.sv
// Bench for flit_inject_arbiter: directed scenarios then randomized traffic, checked against
// a queue-based model of per-source buffers and packet-level round-robin ownership.
module tb_flit_inject_arbiter;
  localparam int unsigned R     = 4;
  localparam int unsigned NODES = 8;
  localparam int unsigned PIDW  = 5;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = $clog2(NODES);
  localparam int unsigned FW    = 3 + 2*DW + 8 + PIDW;

  typedef logic [FW-1:0] flit_t;

  logic clk = 1'b0;
  logic rst;
  logic ce;

  always #5 clk = ~clk;

  flit_inject_arbiter_if #(.REQ_COUNT(R), .FW(FW)) bus ();

  flit_inject_arbiter #(
    .REQ_COUNT(R),
    .NODE_COUNT(NODES),
    .PACKET_ID_WIDTH(PIDW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ce(ce),
    .bus(bus)
  );

  int    vectors     = 0;
  int    miscompares = 0;

  // Model state: queued flits per source, current packet owner (-1 when free), last finished owner
  flit_t mq [R][$];
  int    owner;
  int    last;
  int    drops   [R];
  int    src_seq [R];
  flit_t cur_flit [R];

  logic          s_ce, s_rst, s_rdy;
  logic [R-1:0]  s_v;
  logic [7:0]    exp_d1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, compare, advance the model across the rising edge
  task automatic cyc(input logic c, input logic r, input logic [R-1:0] v, input logic rdy);
    logic [R*FW-1:0] packed_f;
    logic            ev;
    logic [R-1:0]    eg;
    logic [R*8-1:0]  ed;
    int              sz [R];
    flit_t           f;

    ce            = c;
    rst           = r;
    bus.out_ready = rdy;
    bus.in_valid  = v;
    packed_f      = '0;
    for (int i = 0; i < R; i++) begin
      cur_flit[i] = {1'b1, DW'($urandom), 8'($urandom), PIDW'($urandom), DW'(i), 2'(src_seq[i])};
      packed_f[i*FW +: FW] = cur_flit[i];
    end
    bus.in_flit = packed_f;
    #1;

    ev = (owner >= 0) && c && !r && (mq[owner].size() > 0);
    eg = (owner >= 0) ? (R'(1) << owner) : '0;
    ed = '0;
`ifdef FLIT_ARB_DROP_COUNT_EN
    for (int i = 0; i < R; i++) ed[i*8 +: 8] = 8'(drops[i]);
`endif
    check("out_valid", 64'(bus.out_valid), 64'(ev));
    check("grant", 64'(bus.grant), 64'(eg));
    if (ev) check("out_flit", 64'(bus.out_flit), 64'(mq[owner][0]));
    check("drop_count", 64'(bus.drop_count), 64'(ed));

    if (r) begin
      for (int i = 0; i < R; i++) begin
        mq[i].delete();
        drops[i]   = 0;
        src_seq[i] = 0;
      end
      owner = -1;
      last  = R - 1;
    end else if (c) begin
      for (int i = 0; i < R; i++) sz[i] = mq[i].size();
      if (owner < 0) begin
        for (int k = 1; k <= int'(R); k++) begin
          int cnd;
          cnd = (last + k) % int'(R);
          if (owner < 0 && sz[cnd] > 0) owner = cnd;
        end
      end else if (ev && rdy) begin
        f = mq[owner].pop_front();
        if (f[1:0] == 2'd3) begin
          last  = owner;
          owner = -1;
        end
      end
      for (int i = 0; i < R; i++) begin
        if (v[i]) begin
          if (sz[i] < int'(DEPTH)) mq[i].push_back(cur_flit[i]);
          else if (drops[i] < 255) drops[i]++;
          src_seq[i] = (src_seq[i] + 1) % 4;
        end
      end
    end

    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    owner = -1;
    last  = R - 1;
    for (int i = 0; i < R; i++) begin
      drops[i]   = 0;
      src_seq[i] = 0;
    end
    rst           = 1'b1;
    ce            = 1'b0;
    bus.in_valid  = '0;
    bus.in_flit   = '0;
    bus.out_ready = 1'b0;
    @(negedge clk);

    // reset
    cyc(1'b1, 1'b1, 4'b0000, 1'b1);
    cyc(1'b1, 1'b1, 4'b0000, 1'b1);
    check("reset_grant", 64'(bus.grant), 64'd0);
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);

    // single source packet and latency
    repeat (4) cyc(1'b1, 1'b0, 4'b0001, 1'b1);
    repeat (6) cyc(1'b1, 1'b0, 4'b0000, 1'b1);

    // contention between sources 0 and 2
    repeat (4)  cyc(1'b1, 1'b0, 4'b0101, 1'b1);
    repeat (14) cyc(1'b1, 1'b0, 4'b0000, 1'b1);

    // fairness with all sources streaming
    repeat (48) cyc(1'b1, 1'b0, 4'b1111, 1'b1);
    repeat (12) cyc(1'b1, 1'b0, 4'b0000, 1'b1);

    // overflow of source 1 under backpressure
    cyc(1'b1, 1'b1, 4'b0000, 1'b1);
    repeat (6) cyc(1'b1, 1'b0, 4'b0010, 1'b0);
`ifdef FLIT_ARB_DROP_COUNT_EN
    exp_d1 = 8'd2;
`else
    exp_d1 = 8'd0;
`endif
    check("drop_count_src1", 64'(bus.drop_count[15:8]), 64'(exp_d1));
    repeat (8) cyc(1'b1, 1'b0, 4'b0000, 1'b1);

    // reset after the second flit of a locked packet
    repeat (4) cyc(1'b1, 1'b0, 4'b0001, 1'b1);
    cyc(1'b1, 1'b1, 4'b0000, 1'b1);
    check("post_reset_grant", 64'(bus.grant), 64'd0);
    check("post_reset_out_valid", 64'(bus.out_valid), 64'd0);
    repeat (4) cyc(1'b1, 1'b0, 4'b0000, 1'b1);

    // clock-enable gap inside a packet from source 2
    repeat (3) cyc(1'b1, 1'b0, 4'b0100, 1'b1);
    repeat (3) cyc(1'b0, 1'b0, 4'b0000, 1'b1);
    cyc(1'b1, 1'b0, 4'b0100, 1'b1);
    repeat (8) cyc(1'b1, 1'b0, 4'b0000, 1'b1);

    // randomized traffic
    repeat (400) begin
      s_ce  = ($urandom_range(0, 9) != 0);
      s_rst = ($urandom_range(0, 99) == 0);
      s_v   = R'($urandom) & R'($urandom);
      s_rdy = ($urandom_range(0, 3) != 0);
      cyc(s_ce, s_rst, s_v, s_rdy);
    end
    repeat (30) cyc(1'b1, 1'b0, 4'b0000, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
